tiger_memory_stage: RTL

TIGER_MEMORY_STAGE -- requirements
Module: tiger_memory_stage

---
 rtl/tiger_memory_stage.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/tiger_memory_stage.sv
// tiger_memory_stage
//
// Memory stage of the Tiger pipeline. Non-load instructions pass their
// execute result straight through to the registered writeback outputs.
// Loads wait for the memory return. While waiting they request a pipeline
// stall. The returned word is formatted for byte, halfword, LWL/LWR or word
// loads (big-endian), and the result is written back. If the pipeline is
// stalled when data returns, the formatted value is parked in a capture
// buffer (HOLD) until the stall drops.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   stall, clear        global pipeline stall; flush of this stage
//   memread             instruction in this stage is a load
//   mem8, mem16         byte / halfword load
//   memunsigned         zero-extend instead of sign-extend
//   meml, memr          LWL / LWR merge loads
//   regwrite, dest      destination register write request and index
//   resultin            execute result (old rt for LWL/LWR)
//   addrlo              low two bits of the load address
//   memreaddata/valid   memory return data and its qualifier
//   stallRq             combinational request to stall the pipeline
//   regwriteWB, destWB, dataWB   registered writeback outputs
//   memError            sticky flag: a load waited WAIT_LIMIT cycles
module tiger_memory_stage #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        clear,
   input  logic        memread,
   input  logic        mem8,
   input  logic        mem16,
   input  logic        memunsigned,
   input  logic        meml,
   input  logic        memr,
   input  logic        regwrite,
   input  logic [4:0]  dest,
   input  logic [31:0] resultin,
   input  logic [1:0]  addrlo,
   input  logic [31:0] memreaddata,
   input  logic        memreadvalid,
   output logic        stallRq,
   output logic        regwriteWB,
   output logic [4:0]  destWB,
   output logic [31:0] dataWB,
   output logic        memError
);

   localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

   state_t      state, state_n;
   logic [7:0]  count, count_n;
   logic [31:0] buffer, buffer_n;
   logic        error_n;
   logic [31:0] formatted;
   logic        wb_en;
   logic [31:0] wb_data;
   logic [4:0]  wb_dest;
   logic        wb_rw;

   // Big-endian load formatting: byte k lives in bits [31-8k:24-8k].
   function automatic logic [31:0] format_load(
      input logic [31:0] mem,
      input logic [31:0] old,
      input logic [1:0]  k,
      input logic        b8,
      input logic        b16,
      input logic        uns,
      input logic        l,
      input logic        r
   );
      logic [4:0]  sh;
      logic [4:0]  shr;
      logic [31:0] tmp;
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      logic [31:0] res;
      sh     = {k, 3'b000};
      shr    = 5'd24 - sh;
      tmp    = mem >> shr;
      byte_v = tmp[7:0];
      half_v = k[1] ? mem[15:0] : mem[31:16];
      res    = mem;
      if (b8) begin
         res = uns ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      end else if (b16) begin
         res = uns ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      end else if (l) begin
         res = (mem << sh) | (old & ((32'h1 << sh) - 32'h1));
      end else if (r) begin
         res = (mem >> shr) | (old & ~(32'hFFFF_FFFF >> shr));
      end
      return res;
   endfunction

   always_comb begin
      state_n   = state;
      count_n   = count;
      buffer_n  = buffer;
      error_n   = memError;
      stallRq   = 1'b0;
      wb_en     = 1'b0;
      wb_data   = resultin;
      wb_dest   = dest;
      wb_rw     = regwrite && (dest != 5'd0);
      formatted = format_load(memreaddata, resultin, addrlo, mem8, mem16,
                              memunsigned, meml, memr);

      case (state)
         S_IDLE: begin
            if (memread && !memreadvalid) begin
               stallRq = 1'b1;
               count_n = 8'd0;
               state_n = S_WAIT;
            end else if (memread) begin
               buffer_n = formatted;
               if (stall) begin
                  state_n = S_HOLD;
               end else begin
                  wb_en   = 1'b1;
                  wb_data = formatted;
               end
            end else if (!stall) begin
               wb_en = 1'b1;
            end
         end
         S_WAIT: begin
            if (memreadvalid) begin
               buffer_n = formatted;
               if (stall) begin
                  state_n = S_HOLD;
               end else begin
                  wb_en   = 1'b1;
                  wb_data = formatted;
                  state_n = S_IDLE;
               end
            end else begin
               stallRq = 1'b1;
               if (count != 8'hFF) begin
                  count_n = count + 8'd1;
               end
               if (count == LIMIT) begin
                  error_n = 1'b1;
               end
            end
         end
         S_HOLD: begin
            // Memory inputs are ignored here; the captured value is final.
            if (!stall) begin
               wb_en   = 1'b1;
               wb_data = buffer;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // A flush only takes effect when the pipeline is moving.
      if (clear && !stall) begin
         state_n = S_IDLE;
         count_n = 8'd0;
         wb_en   = 1'b1;
         wb_data = 32'h0;
         wb_dest = 5'd0;
         wb_rw   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         count      <= 8'd0;
         buffer     <= 32'h0;
         dataWB     <= 32'h0;
         destWB     <= 5'd0;
         regwriteWB <= 1'b0;
         memError   <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         buffer   <= buffer_n;
         memError <= error_n;
         if (wb_en) begin
            dataWB     <= wb_data;
            destWB     <= wb_dest;
            regwriteWB <= wb_rw;
         end
      end
   end

endmodule
